pc_sequencer: RTL and testbench

- Consumer side of the branch-condition interface. The status-flag block drives the already-selected condition bit `Dcondn`; this block resolves the branch and owns the program counter.
- Holds the 16-bit PC and computes the next PC: sequential, PC-relative conditional branch, or register-indirect jump.
- Inserts a one-cycle flush bubble after any redirect, and supports stall and halt/resume.
- Sits between instruction decode and instruction memory address.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 47 ++++
 rtl/pc_adder.sv | 21 ++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter sequencer.
//   PC_W             : program-counter width (16)
//   RESET_PC_DEFAULT : default PC value loaded on reset
//   state_t          : sequencer FSM states (BOOT=0, RUN=1, FLUSH=2, HALT=3)
//   sext()           : sign-extend the low 'width' bits of a PC_W-bit value
package cpu_pkg;

    localparam int PC_W = 16;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Move the field's sign bit to the MSB, then arithmetic-shift it back down.
    function automatic logic [PC_W-1:0] sext(input logic [PC_W-1:0] raw, input int width);
        logic signed [PC_W-1:0] shifted;
        shifted = signed'(raw << (PC_W - width));
        return unsigned'(shifted >>> (PC_W - width));
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode <-> sequencer bundle.
//   master : decode/flag side; drives Dcondn, br, offset, jr, jr_target,
//            stall, halt, resume (and call, ret with CALL_LINK_EN);
//            observes pc, pc_plus1, flush, taken, state (and lr).
//   slave  : pc_sequencer side, the mirror image.
// Optional feature macro: CALL_LINK_EN adds call, ret and lr.
interface pc_sequencer_if import cpu_pkg::*; #(
    parameter int OFFSET_W = 9
);
    logic                Dcondn;
    logic                br;
    logic [OFFSET_W-1:0] offset;
    logic                jr;
    logic [PC_W-1:0]     jr_target;
    logic                stall;
    logic                halt;
    logic                resume;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_plus1;
    logic                flush;
    logic                taken;
    logic [1:0]          state;
`ifdef CALL_LINK_EN
    logic                call;
    logic                ret;
    logic [PC_W-1:0]     lr;
`endif

    modport master (
`ifdef CALL_LINK_EN
        output call, ret,
        input  lr,
`endif
        output Dcondn, br, offset, jr, jr_target, stall, halt, resume,
        input  pc, pc_plus1, flush, taken, state
    );

    modport slave (
`ifdef CALL_LINK_EN
        input  call, ret,
        output lr,
`endif
        input  Dcondn, br, offset, jr, jr_target, stall, halt, resume,
        output pc, pc_plus1, flush, taken, state
    );

endinterface

// File: rtl/pc_adder.sv
// Next-PC arithmetic for the sequencer (all modulo 2^PC_W).
//   pc_i       : current PC
//   offset_i   : signed word offset, OFFSET_W bits
//   pc_plus1_o : pc_i + 1
//   target_o   : pc_i + 1 + sext(offset_i), shared by branch and call paths
module pc_adder import cpu_pkg::*; #(
    parameter int OFFSET_W = 9
) (
    input  logic [PC_W-1:0]     pc_i,
    input  logic [OFFSET_W-1:0] offset_i,
    output logic [PC_W-1:0]     pc_plus1_o,
    output logic [PC_W-1:0]     target_o
);

    logic [PC_W-1:0] offset_sx;

    assign offset_sx  = sext({{(PC_W-OFFSET_W){1'b0}}, offset_i}, OFFSET_W);
    assign pc_plus1_o = pc_i + PC_W'(1);
    assign target_o   = pc_plus1_o + offset_sx;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, resolves PC-relative branches and
// register-indirect jumps, inserts a one-cycle flush bubble after a redirect,
// and supports stall and halt/resume.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pc_sequencer_if.slave (branch/jump controls in, pc/flush/taken/state out)
// Optional feature macro: CALL_LINK_EN adds call/ret with a link register lr.
module pc_sequencer import cpu_pkg::*; #(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              OFFSET_W = 9
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] rel_target;
`ifdef CALL_LINK_EN
    logic [PC_W-1:0] lr_q, lr_d;
`endif

    pc_adder #(.OFFSET_W(OFFSET_W)) u_adder (
        .pc_i       (pc_q),
        .offset_i   (bus.offset),
        .pc_plus1_o (pc_plus1),
        .target_o   (rel_target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = taken_q;
`ifdef CALL_LINK_EN
        lr_d    = lr_q;
`endif
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.halt) begin
                    state_d = HALT;
                end else if (bus.stall) begin
                    // hold everything
                end else if (bus.jr) begin
                    pc_d    = bus.jr_target;
                    state_d = FLUSH;
                    taken_d = 1'b0;
`ifdef CALL_LINK_EN
                end else if (bus.call) begin
                    lr_d    = pc_plus1;
                    pc_d    = rel_target;
                    state_d = FLUSH;
                    taken_d = 1'b1;
                end else if (bus.ret) begin
                    pc_d    = lr_q;
                    state_d = FLUSH;
                    taken_d = 1'b0;
`endif
                end else if (bus.br && bus.Dcondn) begin
                    pc_d    = rel_target;
                    state_d = FLUSH;
                    taken_d = 1'b1;
                end else begin
                    // sequential fetch; a not-taken branch costs no bubble
                    pc_d    = pc_plus1;
                    taken_d = 1'b0;
                end
            end
            FLUSH: begin
                // The fetched instruction is dead, so its br/jr are ignored.
                if (bus.halt) begin
                    state_d = HALT;
                    taken_d = 1'b0;
                end else if (bus.stall) begin
                    // hold, taken keeps marking the bubble
                end else begin
                    pc_d    = pc_plus1;
                    state_d = RUN;
                    taken_d = 1'b0;
                end
            end
            HALT: begin
                // pc is held so the halted instruction is re-fetched on resume
                if (bus.resume && !bus.halt) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
`ifdef CALL_LINK_EN
            lr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
`ifdef CALL_LINK_EN
            lr_q    <= lr_d;
`endif
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus1 = pc_plus1;
    assign bus.flush    = (state_q == BOOT) || (state_q == FLUSH);
    assign bus.taken    = taken_q;
    assign bus.state    = state_q;
`ifdef CALL_LINK_EN
    assign bus.lr       = lr_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of per-cycle stimulus with expected
// post-edge outputs, pushed to a scoreboard queue when driven and popped
// when the DUT output is sampled; plus hand-written async-reset and
// (with CALL_LINK_EN) call/return sequences.
module tb_pc_sequencer;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.OFFSET_W(9)) bus ();

    pc_sequencer #(.RESET_PC(16'h0000), .OFFSET_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        br;
        logic        dc;
        logic [8:0]  off;
        logic        jr;
        logic [15:0] tgt;
        logic        stall;
        logic        halt;
        logic        resume;
        logic        call;
        logic        ret;
        logic [15:0] pc;
        logic [1:0]  st;
        logic        fl;
        logic        tk;
    } vec_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [1:0]  st;
        logic        fl;
        logic        tk;
    } exp_t;

    vec_t  vecs[$];
    exp_t  sb[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;

    function automatic vec_t mk(input logic br, input logic dc, input logic [8:0] off,
                                input logic jr, input logic [15:0] tgt, input logic stall,
                                input logic halt, input logic resume, input logic call,
                                input logic ret, input logic [15:0] pc, input logic [1:0] st,
                                input logic fl, input logic tk);
        vec_t v;
        v = '{br: br, dc: dc, off: off, jr: jr, tgt: tgt, stall: stall, halt: halt,
              resume: resume, call: call, ret: ret, pc: pc, st: st, fl: fl, tk: tk};
        return v;
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.br        = v.br;
        bus.Dcondn    = v.dc;
        bus.offset    = v.off;
        bus.jr        = v.jr;
        bus.jr_target = v.tgt;
        bus.stall     = v.stall;
        bus.halt      = v.halt;
        bus.resume    = v.resume;
`ifdef CALL_LINK_EN
        bus.call      = v.call;
        bus.ret       = v.ret;
`endif
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input string n, input vec_t v);
        exp_t  e;
        string en;
        drive(v);
        sb.push_back('{pc: v.pc, st: v.st, fl: v.fl, tk: v.tk});
        nq.push_back(n);
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        en = nq.pop_front();
        chk({en, " pc"},       bus.pc,              e.pc);
        chk({en, " state"},    {14'd0, bus.state},  {14'd0, e.st});
        chk({en, " flush"},    {15'd0, bus.flush},  {15'd0, e.fl});
        chk({en, " taken"},    {15'd0, bus.taken},  {15'd0, e.tk});
        chk({en, " pc_plus1"}, bus.pc_plus1,        e.pc + 16'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          br dc off      jr tgt       stl hlt res cal ret  pc        st    fl tk
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0000, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0001, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0002, 2'd1, O, O));
        vecs.push_back(mk(I, I, 9'h1FB, O, 16'h0000, O, O, O, O, O, 16'hFFFE, 2'd2, I, I));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'hFFFF, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0000, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, I, 16'h000F, O, O, O, O, O, 16'h000F, 2'd2, I, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0010, 2'd1, O, O));
        vecs.push_back(mk(I, I, 9'h004, O, 16'h0000, O, O, O, O, O, 16'h0015, 2'd2, I, I));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0016, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, I, 16'h000F, O, O, O, O, O, 16'h000F, 2'd2, I, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0010, 2'd1, O, O));
        vecs.push_back(mk(I, O, 9'h004, O, 16'h0000, O, O, O, O, O, 16'h0011, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, I, 16'h001F, O, O, O, O, O, 16'h001F, 2'd2, I, O));
        vecs.push_back(mk(I, I, 9'h004, I, 16'h5555, O, O, O, O, O, 16'h0020, 2'd1, O, O));
        vecs.push_back(mk(I, I, 9'h004, I, 16'h1234, O, O, O, O, O, 16'h1234, 2'd2, I, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h1235, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, I, O, O, O, O, 16'h1235, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, I, 16'h9999, I, O, O, O, O, 16'h1235, 2'd1, O, O));
        vecs.push_back(mk(I, I, 9'h004, O, 16'h0000, I, O, O, O, O, 16'h1235, 2'd1, O, O));
        vecs.push_back(mk(I, I, 9'h004, O, 16'h0000, O, O, O, O, O, 16'h123A, 2'd2, I, I));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, I, O, O, O, O, 16'h123A, 2'd2, I, I));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, I, O, O, O, O, 16'h123A, 2'd2, I, I));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, I, O, O, O, O, 16'h123A, 2'd2, I, I));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h123B, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, I, 16'h003F, O, O, O, O, O, 16'h003F, 2'd2, I, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0040, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, I, O, O, O, 16'h0040, 2'd3, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, I, I, O, O, 16'h0040, 2'd3, O, O));
        vecs.push_back(mk(I, I, 9'h004, I, 16'h7777, O, O, O, O, O, 16'h0040, 2'd3, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, I, O, O, O, O, 16'h0040, 2'd3, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0040, 2'd3, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, I, O, O, 16'h0040, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0041, 2'd1, O, O));
        vecs.push_back(mk(I, I, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0042, 2'd2, I, I));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, I, O, O, O, 16'h0042, 2'd3, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, I, O, O, 16'h0042, 2'd1, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, I, I, O, O, O, 16'h0042, 2'd3, O, O));
        vecs.push_back(mk(O, O, 9'h000, O, 16'h0000, O, O, I, O, O, 16'h0042, 2'd1, O, O));

        // reset state while rst is held
        drive(mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0000, 2'd0, O, O));
        @(negedge clk);
        chk("reset pc",    bus.pc,             16'h0000);
        chk("reset state", {14'd0, bus.state}, 16'd0);
        chk("reset flush", {15'd0, bus.flush}, 16'd1);
        chk("reset taken", {15'd0, bus.taken}, 16'd0);
`ifdef CALL_LINK_EN
        chk("reset lr",    bus.lr,             16'h0000);
`endif
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("row%0d", i), vecs[i]);
        end

        // asynchronous reset in the middle of a FLUSH cycle
        step("pre_rst_flush", mk(I, I, 9'h004, O, 16'h0000, O, O, O, O, O, 16'h0047, 2'd2, I, I));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_flush pc",    bus.pc,             16'h0000);
        chk("async_flush state", {14'd0, bus.state}, 16'd0);
        chk("async_flush flush", {15'd0, bus.flush}, 16'd1);
        chk("async_flush taken", {15'd0, bus.taken}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        step("boot1", mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0000, 2'd1, O, O));
        step("run1",  mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0001, 2'd1, O, O));
        step("halt1", mk(O, O, 9'h000, O, 16'h0000, O, I, O, O, O, 16'h0001, 2'd3, O, O));

        // asynchronous reset in the middle of HALT
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_halt pc",    bus.pc,             16'h0000);
        chk("async_halt state", {14'd0, bus.state}, 16'd0);
        chk("async_halt flush", {15'd0, bus.flush}, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        step("boot2", mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0000, 2'd1, O, O));

`ifdef CALL_LINK_EN
        step("to2f",  mk(O, O, 9'h000, I, 16'h002F, O, O, O, O, O, 16'h002F, 2'd2, I, O));
        step("at30",  mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0030, 2'd1, O, O));
        step("call",  mk(O, O, 9'h00A, O, 16'h0000, O, O, O, I, O, 16'h003B, 2'd2, I, I));
        chk("call lr", bus.lr, 16'h0031);
        step("post",  mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h003C, 2'd1, O, O));
        step("ret",   mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, I, 16'h0031, 2'd2, I, O));
        step("post2", mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0032, 2'd1, O, O));
        step("callret", mk(O, O, 9'h002, O, 16'h0000, O, O, O, I, I, 16'h0035, 2'd2, I, I));
        chk("callret lr", bus.lr, 16'h0033);
        step("post3", mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0036, 2'd1, O, O));
        step("jrcall", mk(O, O, 9'h002, I, 16'h0100, O, O, O, I, O, 16'h0100, 2'd2, I, O));
        chk("jrcall lr", bus.lr, 16'h0033);
        step("post4", mk(O, O, 9'h000, O, 16'h0000, O, O, O, O, O, 16'h0101, 2'd1, O, O));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
